// File: rtl/pipeline_hazard_ctrl_if.sv
//------------------------------------------------------------------------------
// Module      : pipeline_hazard_ctrl_if
// Description : Hazard controller bus (ID/EX/MEM status in, fetch controls out)
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface pipeline_hazard_ctrl_if #(
    parameter int PC_W  = 8,
    parameter int REG_W = 4,
    parameter int CNT_W = 16
);
    logic              id_valid;
    logic [15:0]       id_instr;
    logic              ex_mem_read;
    logic [REG_W-1:0]  ex_rd;
    logic              ex_branch_taken;
    logic [PC_W-1:0]   ex_branch_target;
    logic              mem_busy;

    logic              stall;
    logic              stall_id;
    logic              bubble_ex;
    logic              flush;
    logic              flush_id;
    logic              PC_sel;
    logic              Jump;
    logic [PC_W-1:0]   branch_target;
    logic              halted;
    logic              mem_err;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output id_valid, id_instr, ex_mem_read, ex_rd,
               ex_branch_taken, ex_branch_target, mem_busy,
        input  stall, stall_id, bubble_ex, flush, flush_id, PC_sel, Jump,
               branch_target, halted, mem_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_instr, ex_mem_read, ex_rd,
               ex_branch_taken, ex_branch_target, mem_busy,
        output stall, stall_id, bubble_ex, flush, flush_id, PC_sel, Jump,
               branch_target, halted, mem_err, stall_cnt, flush_cnt
    );
endinterface

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
//------------------------------------------------------------------------------
// Module      : pipeline_hazard_ctrl
// Description : Pipeline sequencer: stall/flush/jump control, load-use bubbles,
//               memory freeze with timeout, halt latch, performance counters
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pipeline_hazard_ctrl #(
    parameter int          PC_W        = 8,
    parameter int          REG_W       = 4,
    parameter logic [3:0]  OP_LOAD     = 4'h8,
    parameter logic [3:0]  OP_JMP      = 4'hC,
    parameter logic [3:0]  OP_HLT      = 4'hF,
    parameter int          MEM_TIMEOUT = 15,
    parameter int          CNT_W       = 16
) (
    input  wire logic                clk,
    input  wire logic                reset,
    pipeline_hazard_ctrl_if.slave    bus
);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] c_wait_max = WAIT_W'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_HALT     = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic [WAIT_W-1:0]   w_wait_nxt;
    logic                r_mem_err;
    logic [CNT_W-1:0]    r_stall_cnt;
    logic [CNT_W-1:0]    r_flush_cnt;

    logic [3:0]          w_opcode;
    logic [REG_W-1:0]    w_rs1;
    logic [REG_W-1:0]    w_rs2;
    logic                w_load_use;
    logic                w_is_jmp;
    logic                w_is_hlt;
    logic                w_run_eval;

    logic                w_stall;
    logic                w_stall_id;
    logic                w_bubble_ex;
    logic                w_flush;
    logic                w_flush_id;
    logic                w_pc_sel;
    logic                w_jump;

    // The loader opcode and rd field are decoded elsewhere; only EX's load flag matters here.
    logic w_unused_fields;
    assign w_unused_fields = &{1'b0, bus.id_instr[11:8], OP_LOAD};

    assign w_opcode   = bus.id_instr[15:12];
    assign w_rs1      = bus.id_instr[4 +: REG_W];
    assign w_rs2      = bus.id_instr[0 +: REG_W];
    assign w_is_jmp   = bus.id_valid && (w_opcode == OP_JMP);
    assign w_is_hlt   = bus.id_valid && (w_opcode == OP_HLT);
    assign w_load_use = bus.id_valid && bus.ex_mem_read &&
                        ((bus.ex_rd == w_rs1) || (bus.ex_rd == w_rs2)) &&
                        !w_is_jmp && !w_is_hlt;

    always_comb begin
        w_state_nxt = r_state;
        w_run_eval  = 1'b0;
        w_stall     = 1'b0;
        w_stall_id  = 1'b0;
        w_bubble_ex = 1'b0;
        w_flush     = 1'b0;
        w_flush_id  = 1'b0;
        w_pc_sel    = 1'b0;
        w_jump      = 1'b0;

        case (r_state)
            S_RUN: begin
                if (bus.mem_busy) begin
                    w_stall     = 1'b1;
                    w_stall_id  = 1'b1;
                    w_state_nxt = S_MEM_WAIT;
                end else begin
                    w_run_eval = 1'b1;
                end
            end
            S_MEM_WAIT: begin
                if (bus.mem_busy) begin
                    w_stall    = 1'b1;
                    w_stall_id = 1'b1;
                end else begin
                    // Release cycle resolves whatever EX/ID held during the freeze.
                    w_run_eval  = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_HALT: begin
                w_stall    = 1'b1;
                w_stall_id = 1'b1;
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase

        if (w_run_eval) begin
            if (bus.ex_branch_taken) begin
                w_pc_sel   = 1'b1;
                w_flush    = 1'b1;
                w_flush_id = 1'b1;
            end else if (w_is_hlt) begin
                w_stall     = 1'b1;
                w_stall_id  = 1'b1;
                w_state_nxt = S_HALT;
            end else if (w_is_jmp) begin
                w_jump  = 1'b1;
                w_flush = 1'b1;
            end else if (w_load_use) begin
                w_stall     = 1'b1;
                w_stall_id  = 1'b1;
                w_bubble_ex = 1'b1;
            end
        end
    end

    // Wait counter tracks consecutive busy cycles, including the one that entered the freeze.
    always_comb begin
        w_wait_nxt = '0;
        if (bus.mem_busy) begin
            if (r_state == S_RUN) begin
                w_wait_nxt = WAIT_W'(1);
            end else if (r_state == S_MEM_WAIT) begin
                w_wait_nxt = (r_wait_cnt == c_wait_max) ? r_wait_cnt
                                                         : r_wait_cnt + WAIT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_RUN;
            r_wait_cnt  <= '0;
            r_mem_err   <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            if (w_wait_nxt == c_wait_max) begin
                r_mem_err <= 1'b1;
            end
            if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_flush && (r_flush_cnt != {CNT_W{1'b1}})) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.stall         = w_stall;
    assign bus.stall_id      = w_stall_id;
    assign bus.bubble_ex     = w_bubble_ex;
    assign bus.flush         = w_flush;
    assign bus.flush_id      = w_flush_id;
    assign bus.PC_sel        = w_pc_sel;
    assign bus.Jump          = w_jump;
    assign bus.branch_target = bus.ex_branch_target;
    assign bus.halted        = (r_state == S_HALT);
    assign bus.mem_err       = r_mem_err;
    assign bus.stall_cnt     = r_stall_cnt;
    assign bus.flush_cnt     = r_flush_cnt;

endmodule

`default_nettype wire
